// File: rtl/y86_pipe_stage_reg_pkg.sv
// Shared Y86 pipeline constants: NOP/status/register encodings and the bundle field layout
// used to build each stage's BUBBLE_VAL.
package y86_pipe_stage_reg_pkg;

  localparam int unsigned DEF_DATA_W = 96;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] S_OK   = 4'h1;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam int unsigned STAT_LSB  = 92;
  localparam int unsigned ICODE_LSB = 88;
  localparam int unsigned IFUN_LSB  = 84;
  localparam int unsigned RA_LSB    = 4;
  localparam int unsigned RB_LSB    = 0;

  // Canonical 96-bit NOP bundle: S_OK, I_NOP, ifun 0, zero values, no register ids.
  function automatic logic [DEF_DATA_W-1:0] nop_bundle();
    logic [DEF_DATA_W-1:0] b;
    b = '0;
    b[STAT_LSB  +: 4] = S_OK;
    b[ICODE_LSB +: 4] = I_NOP;
    b[RA_LSB    +: 4] = R_NONE;
    b[RB_LSB    +: 4] = R_NONE;
    return b;
  endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter; cleared only by synchronous reset.
module y86_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Elastic Y86 stage register: valid/ready handshake with 2-entry skid, stall/bubble control.
// Optional macro Y86_PIPE_PERF_CNT_EN adds saturating bubble/stall cycle counters.
import y86_pipe_stage_reg_pkg::*;

module y86_pipe_stage_reg #(
  parameter int unsigned            DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0]      BUBBLE_VAL = '0,
  parameter int unsigned            CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef Y86_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              acc, drn;

  assign in_ready  = !stall && !skid_v_q;
  assign out_valid = main_v_q && !stall;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign out_data  = main_data_q;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  // Next state: bubble flushes, stall freezes, otherwise skid drains ahead of new input.
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (bubble) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
    end else if (!stall) begin
      if (!main_v_q || drn) begin
        if (skid_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = skid_data_q;
          skid_v_d    = acc;
          if (acc) skid_data_d = in_data;
        end else begin
          main_v_d = acc;
          if (acc) main_data_d = in_data;
        end
      end else if (acc) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= BUBBLE_VAL;
      skid_data_q <= BUBBLE_VAL;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef Y86_PIPE_PERF_CNT_EN
  y86_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble),
    .count (bubble_cnt)
  );

  y86_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall && !bubble),
    .count (stall_cnt)
  );
`endif

endmodule
